pcm_sample_feeder: RTL and testbench
====================================

// Module: pcm_sample_feeder
// PURPOSE
//   Sample-rate source for the MFCC front end. Buffers PCM samples pushed by an upstream producer
//   (host/codec bridge) in a small FIFO, then presents them on x_i with a write strobe at a fixed
//   rate. x_i/write connect directly to MFCC.x_i/MFCC.write.
//   One sample per SAMPLE_PERIOD clocks; x_i held stable for the whole period; write asserted at
//   the end of the period.
// PARAMETERS
//   SAMPLE_PERIOD  3125  clocks per output sample, >= WRITE_LEN+1
//   WRITE_LEN      1     write pulse width in clocks, >= 1
//   FIFO_DEPTH     16    input FIFO entries, power of 2, >= 2
//   ADDR_W         4     log2(FIFO_DEPTH)
// PORTS
//   clk          in   1         single system clock, all logic rising-edge
//   reset        in   1         synchronous, active-high
//   in_data      in   16        signed PCM sample from producer
//   in_valid     in   1         producer offers in_data this cycle
//   in_ready     out  1         FIFO can accept; push when in_valid&&in_ready
//   enable       in   1         run the sample pacer
//   x_i          out  16        signed sample to MFCC, registered
//   write        out  1         sample strobe to MFCC, registered
//   underrun     out  1         1-cycle pulse: period started with FIFO empty
//   fifo_level   out  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH
//   sample_count out  16        number of write pulses started, wraps at 65535->0
// BEHAVIOUR
//   Reset (while reset=1, sampled at clk): x_i=0, write=0, underrun=0, fifo_level=0, sample_count=0,
//     period counter cnt=0, FIFO pointers cleared. Pushes during reset are discarded.
//     in_ready = !full (combinational from registered state), so in_ready=1 during and after reset.
//   FIFO
//     - Push when in_valid&&in_ready.
//     - in_ready depends on registered full only. A pop in the same cycle does not open a slot.
//     - No fall-through: a sample pushed in cycle t is poppable no earlier than t+1.
//     - Simultaneous push and pop: fifo_level is unchanged.
//   Pacer: cnt counts 0..SAMPLE_PERIOD-1 while enable=1, then wraps to 0.
//     - Load cycle (enable=1 && cnt==0):
//         FIFO non-empty -> pop; x_i <= head (visible next cycle).
//         FIFO empty     -> x_i <= 0; underrun pulses for the next cycle.
//     - write=1 exactly on cycles with cnt in [SAMPLE_PERIOD-WRITE_LEN, SAMPLE_PERIOD-1] (registered,
//       so write is aligned to those cnt values). sample_count increments on the first write cycle.
//     - Latency: a sample already in the FIFO at the load edge appears on x_i 1 clock later.
//       Its write begins SAMPLE_PERIOD-WRITE_LEN clocks after the load edge.
//     - x_i changes only on a load, never while write=1.
//   enable=0: cnt forced to 0, write forced to 0 next cycle, x_i holds, no pops.
//     Deasserting enable mid-period aborts that period: no write, and the loaded sample is consumed.
//     Re-asserting enable: the first cycle is a load cycle.
//   Wrap-around: FIFO pointers are ADDR_W+1 bits; full when the MSBs differ and the low bits are
//     equal. sample_count wraps silently.
//   Reset mid-period: write and underrun drop on the next edge; buffered samples are lost.
// TESTING (run with SAMPLE_PERIOD=8, WRITE_LEN=1, FIFO_DEPTH=4)
//   1. Push 0x0001,0x0002,0x0003, then enable=1 -> x_i = 1,2,3 in successive 8-cycle periods;
//      write high on cnt==7 of each period; sample_count = 3 after the third pulse.
//   2. Enable with empty FIFO -> underrun 1-cycle pulse each period, x_i=0, write still pulses every
//      8 cycles, sample_count increments.
//   3. Push 5 samples back-to-back, no enable -> in_ready=0 after 4 pushes, fifo_level=4, 5th
//      sample dropped by protocol (producer stalls).
//   4. FIFO full, push offered on the load cycle -> pop occurs, push refused that cycle,
//      accepted next cycle; fifo_level 4->3->4.
//   5. Drop enable at cnt==4 -> no write that period, x_i unchanged, cnt=0.
//      Re-enable -> next sample loaded immediately.
//   6. Assert reset at cnt==7 with write=1 -> write=0, fifo_level=0, x_i=0, sample_count=0 next cycle.
//   Also fill/drain the FIFO 3x continuously to cover pointer wrap-around; data order is preserved.

Source files
------------

// File: rtl/pcm_sample_feeder.sv
// Fixed-rate PCM sample source for the MFCC front end.
// A small FIFO absorbs producer bursts; a period counter paces x_i/write to the consumer.
module pcm_sample_feeder #(
  parameter int SAMPLE_PERIOD = 3125,
  parameter int WRITE_LEN     = 1,
  parameter int FIFO_DEPTH    = 16,
  parameter int ADDR_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              enable,
  output logic [15:0]       x_i,
  output logic              write,
  output logic              underrun,
  output logic [ADDR_W:0]   fifo_level,
  output logic [15:0]       sample_count
);

  localparam int CNT_W = $clog2(SAMPLE_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [CNT_W-1:0] WR_FIRST = CNT_W'(SAMPLE_PERIOD - WRITE_LEN);

  logic [15:0]      mem [FIFO_DEPTH];
  logic [ADDR_W:0]  wptr;
  logic [ADDR_W:0]  rptr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             full;
  logic             empty;
  logic             push;
  logic             load;
  logic             pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full       = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                      (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign empty      = (wptr == rptr);
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign load       = enable && (cnt == '0);
  assign pop        = load && !empty;
  assign fifo_level = wptr - rptr;

  always_comb begin
    cnt_nxt = '0;
    if (enable && (cnt != CNT_LAST)) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wptr[ADDR_W-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr         <= '0;
      rptr         <= '0;
      cnt          <= '0;
      x_i          <= '0;
      write        <= 1'b0;
      underrun     <= 1'b0;
      sample_count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      cnt      <= cnt_nxt;
      // write is registered from the next count so it lines up with cnt itself.
      write    <= (cnt_nxt >= WR_FIRST);
      underrun <= load && empty;
      if (load) begin
        x_i <= empty ? 16'h0000 : mem[rptr[ADDR_W-1:0]];
      end
      if (cnt_nxt == WR_FIRST) begin
        sample_count <= sample_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pcm_sample_feeder.sv
// Directed bench for pcm_sample_feeder with SAMPLE_PERIOD=8, WRITE_LEN=1, FIFO_DEPTH=4.
module tb_pcm_sample_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        enable;
  logic [15:0] x_i;
  logic        write;
  logic        underrun;
  logic [2:0]  fifo_level;
  logic [15:0] sample_count;

  int total = 0;
  int bad   = 0;

  pcm_sample_feeder #(
    .SAMPLE_PERIOD(8),
    .WRITE_LEN    (1),
    .FIFO_DEPTH   (4),
    .ADDR_W       (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .enable       (enable),
    .x_i          (x_i),
    .write        (write),
    .underrun     (underrun),
    .fifo_level   (fifo_level),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [15:0] data;
    logic        en;
    logic        rdy;
    logic [2:0]  lvl;
    logic [15:0] x;
    logic        wr;
    logic        ur;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic vld, input logic [15:0] data,
                              input logic en, input logic rdy, input logic [2:0] lvl,
                              input logic [15:0] x, input logic wr, input logic ur);
    vec_t v;
    v.rst = rst; v.vld = vld; v.data = data; v.en = en;
    v.rdy = rdy; v.lvl = lvl; v.x = x; v.wr = wr; v.ur = ur;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    reset    = v.rst;
    in_valid = v.vld;
    in_data  = v.data;
    enable   = v.en;
    tick();
    chk({tag, ".rdy"}, {31'd0, in_ready}, {31'd0, v.rdy});
    chk({tag, ".lvl"}, {29'd0, fifo_level}, {29'd0, v.lvl});
    chk({tag, ".x"},   {16'd0, x_i}, {16'd0, v.x});
    chk({tag, ".wr"},  {31'd0, write}, {31'd0, v.wr});
    chk({tag, ".ur"},  {31'd0, underrun}, {31'd0, v.ur});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t0 [5];
    vec_t t1 [10];
    int p, k, sent, rcv, urs;
    logic acc;

    // reset (pushes discarded), then three pushes with the pacer idle
    t0[0] = mk(1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0);
    t0[1] = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0);
    t0[2] = mk(1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 3'd1, 16'h0000, 1'b0, 1'b0);
    t0[3] = mk(1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 3'd2, 16'h0000, 1'b0, 1'b0);
    t0[4] = mk(1'b0, 1'b1, 16'h0003, 1'b0, 1'b1, 3'd3, 16'h0000, 1'b0, 1'b0);

    // fill to full, refused 5th push, pop on load frees slot next cycle, abort at cnt==4
    t1[0] = mk(1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 3'd1, 16'h0000, 1'b0, 1'b0);
    t1[1] = mk(1'b0, 1'b1, 16'h0022, 1'b0, 1'b1, 3'd2, 16'h0000, 1'b0, 1'b0);
    t1[2] = mk(1'b0, 1'b1, 16'h0033, 1'b0, 1'b1, 3'd3, 16'h0000, 1'b0, 1'b0);
    t1[3] = mk(1'b0, 1'b1, 16'h0044, 1'b0, 1'b0, 3'd4, 16'h0000, 1'b0, 1'b0);
    t1[4] = mk(1'b0, 1'b1, 16'h0055, 1'b0, 1'b0, 3'd4, 16'h0000, 1'b0, 1'b0);
    t1[5] = mk(1'b0, 1'b1, 16'h0055, 1'b1, 1'b1, 3'd3, 16'h0011, 1'b0, 1'b0);
    t1[6] = mk(1'b0, 1'b1, 16'h0055, 1'b1, 1'b0, 3'd4, 16'h0011, 1'b0, 1'b0);
    t1[7] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd4, 16'h0011, 1'b0, 1'b0);
    t1[8] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd4, 16'h0011, 1'b0, 1'b0);
    t1[9] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd4, 16'h0011, 1'b0, 1'b0);

    reset = 1'b1; in_valid = 1'b0; in_data = 16'h0000; enable = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(t0[i], $sformatf("t0[%0d]", i));
    chk("t0.sc", {16'd0, sample_count}, 32'd0);

    // three buffered samples played out one per period
    in_valid = 1'b0;
    enable   = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      tick();
      p = (e - 1) / 8;
      k = (e - 1) % 8 + 1;
      chk("t1.x",   {16'd0, x_i}, p + 1);
      chk("t1.wr",  {31'd0, write}, {31'd0, (k == 7)});
      chk("t1.lvl", {29'd0, fifo_level}, 2 - p);
      chk("t1.sc",  {16'd0, sample_count}, p + ((k >= 7) ? 1 : 0));
      chk("t1.ur",  {31'd0, underrun}, 32'd0);
    end

    // empty FIFO: underrun each load, x_i=0, writes keep coming
    for (int e = 1; e <= 16; e++) begin
      tick();
      p = (e - 1) / 8;
      k = (e - 1) % 8 + 1;
      chk("t2.x",   {16'd0, x_i}, 32'd0);
      chk("t2.ur",  {31'd0, underrun}, {31'd0, (k == 1)});
      chk("t2.wr",  {31'd0, write}, {31'd0, (k == 7)});
      chk("t2.sc",  {16'd0, sample_count}, 3 + p + ((k >= 7) ? 1 : 0));
      chk("t2.lvl", {29'd0, fifo_level}, 32'd0);
    end
    enable = 1'b0;
    tick();
    chk("t2.off.wr", {31'd0, write}, 32'd0);
    chk("t2.off.sc", {16'd0, sample_count}, 32'd5);

    for (int i = 0; i < 10; i++) run_vec(t1[i], $sformatf("t1v[%0d]", i));

    // stay disabled: nothing moves
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5.off.wr",  {31'd0, write}, 32'd0);
      chk("t5.off.x",   {16'd0, x_i}, 32'h11);
      chk("t5.off.lvl", {29'd0, fifo_level}, 32'd4);
    end
    chk("t5.off.sc", {16'd0, sample_count}, 32'd5);

    // re-enable: immediate load, two periods, stop with write high
    enable = 1'b1;
    for (int kk = 1; kk <= 15; kk++) begin
      tick();
      chk("t5.x",   {16'd0, x_i}, (kk <= 8) ? 32'h22 : 32'h33);
      chk("t5.lvl", {29'd0, fifo_level}, (kk <= 8) ? 32'd3 : 32'd2);
      chk("t5.wr",  {31'd0, write}, {31'd0, (kk == 7 || kk == 15)});
      chk("t5.sc",  {16'd0, sample_count},
          5 + ((kk >= 7) ? 1 : 0) + ((kk >= 15) ? 1 : 0));
    end

    // reset while write=1
    reset = 1'b1;
    tick();
    chk("t6.wr",  {31'd0, write}, 32'd0);
    chk("t6.lvl", {29'd0, fifo_level}, 32'd0);
    chk("t6.x",   {16'd0, x_i}, 32'd0);
    chk("t6.sc",  {16'd0, sample_count}, 32'd0);
    chk("t6.ur",  {31'd0, underrun}, 32'd0);
    chk("t6.rdy", {31'd0, in_ready}, 32'd1);

    // continuous fill/drain over several pointer wraps, order preserved
    reset = 1'b0; enable = 1'b0;
    sent = 0; rcv = 0; urs = 0;
    for (int c = 0; c < 400 && rcv < 16; c++) begin
      in_valid = (sent < 16);
      in_data  = 16'h0100 + 16'(sent);
      if (sent >= 4) enable = 1'b1;
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
      if (underrun) urs++;
      if (write) begin
        chk($sformatf("wrap.x[%0d]", rcv), {16'd0, x_i}, 32'h0100 + rcv);
        rcv++;
      end
    end
    in_valid = 1'b0;
    chk("wrap.rcv", rcv, 32'd16);
    chk("wrap.ur",  urs, 32'd0);
    chk("wrap.sc",  {16'd0, sample_count}, 32'd16);
    chk("wrap.lvl", {29'd0, fifo_level}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
